// File: rtl/mme_pkg.sv
// Shared constants and types for the multimedia execute pipeline.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mme_pkg;

  localparam int REG_WIDTH  = 128;
  localparam int IDX_WIDTH  = 5;
  localparam int OP_WIDTH   = 8;
  localparam int CTRL_WIDTH = 2;

  // R4 ctrl bit positions
  localparam int CTRL_SUB = 1;  // multiply-subtract instead of multiply-add
  localparam int CTRL_HI  = 0;  // operate on the high halfword

  typedef enum logic [OP_WIDTH-1:0] {
    OP_NOP    = 8'h00,
    OP_MADD_W = 8'h01,
    OP_MADD_L = 8'h02,
    OP_ADD_H  = 8'h10,
    OP_SUB_H  = 8'h11,
    OP_AND    = 8'h20,
    OP_OR     = 8'h21,
    OP_XOR    = 8'h22
  } mme_op_e;

  // Control fields that travel alongside the operands into EX
  typedef struct packed {
    logic [OP_WIDTH-1:0]   opcode;
    logic [CTRL_WIDTH-1:0] ctrl;
    logic                  we;
    logic [IDX_WIDTH-1:0]  rd_idx;
  } id_ex_hdr_t;

  // r0 is hardwired to zero regardless of what the register file returns
  function automatic logic [REG_WIDTH-1:0] zero_r0(input logic [IDX_WIDTH-1:0] idx,
                                                   input logic [REG_WIDTH-1:0] data);
    return (idx == '0) ? '0 : data;
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Operand source select: register file, writeback bypass, or held value.
// Latency: combinational.
// Backpressure: none; the caller decides when the result is registered.
module fwd_select
  import mme_pkg::*;
(
  input  logic [IDX_WIDTH-1:0] idx,
  input  logic [REG_WIDTH-1:0] rf_data,
  input  logic [REG_WIDTH-1:0] held_data,
  input  logic                 held,
  input  logic                 wb_we,
  input  logic [IDX_WIDTH-1:0] wb_idx,
  input  logic [REG_WIDTH-1:0] wb_data,
  output logic [REG_WIDTH-1:0] next_data
);

  logic wb_hit;

  // A writeback to r0 never counts as a hit
  assign wb_hit = wb_we && (idx != '0) && (wb_idx == idx);

  // Held operands only change on a bypass hit; fresh ones obey the r0 rule first
  always_comb begin
    next_data = held_data;
    if (held) begin
      if (wb_hit) next_data = wb_data;
    end else begin
      next_data = wb_hit ? wb_data : zero_r0(idx, rf_data);
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: one instruction + three resolved 128-bit operands for the ALU.
// Latency: 1 cycle in -> out; a held entry can be replaced on the same edge it drains.
// Backpressure: in_ready = !out_valid | out_ready (single entry); flush drops held and incoming.
// Build option: define ID_EX_FORWARD_EN to bypass the writeback bus at capture and while stalled.
module id_ex_stage
  import mme_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OP_WIDTH-1:0]   in_opcode,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_we,
  input  logic [IDX_WIDTH-1:0]  in_rd_idx,
  input  logic [IDX_WIDTH-1:0]  in_rs1_idx,
  input  logic [IDX_WIDTH-1:0]  in_rs2_idx,
  input  logic [IDX_WIDTH-1:0]  in_rs3_idx,
  input  logic [REG_WIDTH-1:0]  in_rs1_data,
  input  logic [REG_WIDTH-1:0]  in_rs2_data,
  input  logic [REG_WIDTH-1:0]  in_rs3_data,
  input  logic                  wb_we,
  input  logic [IDX_WIDTH-1:0]  wb_idx,
  input  logic [REG_WIDTH-1:0]  wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OP_WIDTH-1:0]   out_opcode,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_we,
  output logic [IDX_WIDTH-1:0]  out_rd_idx,
  output logic [REG_WIDTH-1:0]  out_rs1,
  output logic [REG_WIDTH-1:0]  out_rs2,
  output logic [REG_WIDTH-1:0]  out_rs3
);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e               state_q, state_d;
  logic                 load;
  id_ex_hdr_t           hdr_q;
  logic [IDX_WIDTH-1:0] src_idx  [3];
  logic [REG_WIDTH-1:0] src_data [3];
  logic [REG_WIDTH-1:0] rs_q     [3];
  logic [REG_WIDTH-1:0] rs_d     [3];
  logic                 rs_en;

  assign out_valid = (state_q == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign load      = in_valid && in_ready && !flush;

  assign src_idx[0]  = in_rs1_idx;
  assign src_idx[1]  = in_rs2_idx;
  assign src_idx[2]  = in_rs3_idx;
  assign src_data[0] = in_rs1_data;
  assign src_data[1] = in_rs2_data;
  assign src_data[2] = in_rs3_data;

  // Occupancy state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // Next occupancy: flush wins, then load (also covers load+drain), then drain
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (load) state_d = FULL;
      FULL: begin
        if (flush)          state_d = EMPTY;
        else if (load)      state_d = FULL;
        else if (out_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  // Control fields: captured on load; a flush only needs to kill the write enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hdr_q <= '0;
    end else if (flush) begin
      hdr_q.we <= 1'b0;
    end else if (load) begin
      hdr_q <= '{opcode: in_opcode, ctrl: in_ctrl, we: in_we, rd_idx: in_rd_idx};
    end
  end

`ifdef ID_EX_FORWARD_EN
  logic                 stall;
  logic [IDX_WIDTH-1:0] held_idx_q [3];

  assign stall = out_valid && !out_ready;
  // Held operands may pick up a writeback while the stage is stalled
  assign rs_en = load || (stall && !flush);

  for (genvar i = 0; i < 3; i++) begin : g_fwd
    fwd_select u_fwd (
      .idx       (load ? src_idx[i] : held_idx_q[i]),
      .rf_data   (src_data[i]),
      .held_data (rs_q[i]),
      .held      (!load),
      .wb_we     (wb_we),
      .wb_idx    (wb_idx),
      .wb_data   (wb_data),
      .next_data (rs_d[i])
    );

    // Source index kept so a stalled operand knows which writeback to watch
    always_ff @(posedge clk or posedge rst) begin
      if (rst)       held_idx_q[i] <= '0;
      else if (load) held_idx_q[i] <= src_idx[i];
    end
  end
`else
  logic unused_wb;

  assign unused_wb = ^{wb_we, wb_idx, wb_data};
  assign rs_en     = load;

  for (genvar i = 0; i < 3; i++) begin : g_nofwd
    assign rs_d[i] = zero_r0(src_idx[i], src_data[i]);
  end
`endif

  // Operand registers
  for (genvar i = 0; i < 3; i++) begin : g_rs
    always_ff @(posedge clk or posedge rst) begin
      if (rst)        rs_q[i] <= '0;
      else if (rs_en) rs_q[i] <= rs_d[i];
    end
  end

  assign out_opcode = hdr_q.opcode;
  assign out_ctrl   = hdr_q.ctrl;
  assign out_we     = hdr_q.we;
  assign out_rd_idx = hdr_q.rd_idx;
  assign out_rs1    = rs_q[0];
  assign out_rs2    = rs_q[1];
  assign out_rs3    = rs_q[2];

endmodule
